// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer between EX/MEM and a req/ack memory port.
// Stalls the pipeline for the duration of each access and flags misalignment and timeouts.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        MemRead_In,
    input  logic        MemWrite_In,
    input  logic [1:0]  ByteSel_In,
    input  logic [31:0] Addr_In,
    input  logic [31:0] WData_In,
    output logic        Mem_Req,
    output logic        Mem_We,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_WData,
    output logic [3:0]  Mem_ByteEn,
    input  logic        Mem_Ack,
    input  logic [31:0] Mem_RData,
    output logic        Stall,
    output logic [31:0] RData_Out,
    output logic        RData_Valid,
    output logic        Misalign_Err,
    output logic        Timeout_Err
);

    // state  | meaning
    // IDLE   | no access in flight; decode EX/MEM
    // WAIT   | request outstanding, counting cycles to timeout
    // DONE   | access finished; EX/MEM still holds it, so inputs are ignored
    // ERR    | memory never acked; pipeline frozen until reset
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              valid_q, valid_d;
    logic              mis_err_q, mis_err_d;
    logic              to_err_q, to_err_d;
    logic              stall_c;

    logic              acc, mis, is_half, is_byte, is_word;
    logic [3:0]        be_dec;
    logic [31:0]       wdata_dec;

    always_comb begin
        acc     = MemRead_In | MemWrite_In;
        is_half = (ByteSel_In == 2'b01);
        is_byte = (ByteSel_In == 2'b10);
        is_word = !is_half && !is_byte;
        mis     = (is_word && (Addr_In[1:0] != 2'b00)) || (is_half && Addr_In[0]);
        if (is_half) begin
            be_dec    = Addr_In[1] ? 4'b1100 : 4'b0011;
            wdata_dec = {2{WData_In[15:0]}};
        end else if (is_byte) begin
            be_dec    = 4'b0001 << Addr_In[1:0];
            wdata_dec = {4{WData_In[7:0]}};
        end else begin
            be_dec    = 4'b1111;
            wdata_dec = WData_In;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        mis_err_d = mis_err_q;
        to_err_d  = to_err_q;
        stall_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    if (mis) begin
                        mis_err_d = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        we_d    = MemWrite_In;
                        addr_d  = {Addr_In[31:2], 2'b00};
                        wdata_d = wdata_dec;
                        be_d    = be_dec;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (Mem_Ack) begin
                    if (!we_q) begin
                        rdata_d = Mem_RData;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    to_err_d = 1'b1;
                    state_d  = S_ERR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                stall_c = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Req and valid come straight from flops so the port sees glitch-free levels.
        req_d   = (state_d == S_WAIT);
        valid_d = (state_d == S_DONE) && !we_d;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
            valid_q   <= 1'b0;
            mis_err_q <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            valid_q   <= valid_d;
            mis_err_q <= mis_err_d;
            to_err_q  <= to_err_d;
        end
    end

    // Stall is combinational in IDLE, so it is masked to keep it low while reset is held.
    assign Stall        = stall_c & Reset_n;
    assign Mem_Req      = req_q;
    assign Mem_We       = we_q;
    assign Mem_Addr     = addr_q;
    assign Mem_WData    = wdata_q;
    assign Mem_ByteEn   = be_q;
    assign RData_Out    = rdata_q;
    assign RData_Valid  = valid_q;
    assign Misalign_Err = mis_err_q;
    assign Timeout_Err  = to_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: transaction-level reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_mem_access_ctrl;

    localparam int unsigned TIMEOUT = 4;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        MemRead_In, MemWrite_In;
    logic [1:0]  ByteSel_In;
    logic [31:0] Addr_In, WData_In;
    logic        Mem_Req, Mem_We;
    logic [31:0] Mem_Addr, Mem_WData;
    logic [3:0]  Mem_ByteEn;
    logic        Mem_Ack;
    logic [31:0] Mem_RData;
    logic        Stall;
    logic [31:0] RData_Out;
    logic        RData_Valid, Misalign_Err, Timeout_Err;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .MemRead_In(MemRead_In), .MemWrite_In(MemWrite_In),
        .ByteSel_In(ByteSel_In), .Addr_In(Addr_In), .WData_In(WData_In),
        .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr),
        .Mem_WData(Mem_WData), .Mem_ByteEn(Mem_ByteEn),
        .Mem_Ack(Mem_Ack), .Mem_RData(Mem_RData),
        .Stall(Stall), .RData_Out(RData_Out), .RData_Valid(RData_Valid),
        .Misalign_Err(Misalign_Err), .Timeout_Err(Timeout_Err)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sel);
        return (sel == 2'b01) ? 2 : (sel == 2'b10) ? 1 : 4;
    endfunction

    function automatic bit misaligned(input logic [1:0] sel, input logic [31:0] a);
        return (a % nbytes(sel)) != 0;
    endfunction

    // Reference model: one pending access, how long it has waited, and the sticky flags.
    bit          m_busy, m_done, m_dead, m_mis, m_terr, m_we;
    int          m_waited;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            m_busy = 0; m_done = 0; m_dead = 0; m_mis = 0; m_terr = 0; m_we = 0;
            m_waited = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_be = 0;
        end else if (m_dead) begin
        end else if (m_busy) begin
            if (Mem_Ack) begin
                m_busy = 0;
                m_done = 1;
                if (!m_we) m_rdata = Mem_RData;
            end else begin
                m_waited++;
                if (m_waited == TIMEOUT) begin
                    m_busy = 0; m_dead = 1; m_terr = 1;
                end
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (MemRead_In || MemWrite_In) begin
            if (misaligned(ByteSel_In, Addr_In)) begin
                m_mis = 1;
            end else begin
                int n;
                n        = nbytes(ByteSel_In);
                m_busy   = 1;
                m_waited = 0;
                m_we     = MemWrite_In;
                m_addr   = Addr_In & ~32'd3;
                m_be     = 4'(((1 << n) - 1) << (Addr_In % 4));
                m_wdata  = (n == 4) ? WData_In :
                           (n == 2) ? (WData_In & 32'hFFFF) * 32'h0001_0001 :
                                      (WData_In & 32'hFF) * 32'h0101_0101;
            end
        end
    end

    int   stall_cnt, req_cnt, valid_cnt;
    logic seen_we;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;

    always @(negedge Clock) begin
        bit e_stall;
        e_stall = Reset_n && (m_busy || m_dead ||
                  (!m_done && (MemRead_In || MemWrite_In) && !misaligned(ByteSel_In, Addr_In)));
        chk("cyc_stall", 32'(Stall), 32'(e_stall));
        chk("cyc_req", 32'(Mem_Req), 32'(m_busy));
        chk("cyc_valid", 32'(RData_Valid), 32'(m_done && !m_we));
        chk("cyc_rdata", RData_Out, m_rdata);
        chk("cyc_mis", 32'(Misalign_Err), 32'(m_mis));
        chk("cyc_tmo", 32'(Timeout_Err), 32'(m_terr));
        if (m_busy) begin
            chk("cyc_we", 32'(Mem_We), 32'(m_we));
            chk("cyc_addr", Mem_Addr, m_addr);
            chk("cyc_wdata", Mem_WData, m_wdata);
            chk("cyc_be", 32'(Mem_ByteEn), 32'(m_be));
        end
        if (Stall) stall_cnt++;
        if (RData_Valid) valid_cnt++;
        if (Mem_Req) begin
            req_cnt++;
            seen_we = Mem_We; seen_addr = Mem_Addr; seen_wdata = Mem_WData; seen_be = Mem_ByteEn;
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_counts();
        stall_cnt = 0; req_cnt = 0; valid_cnt = 0;
    endtask

    task automatic set_acc(input bit rd, input bit wr, input logic [1:0] sel,
                           input logic [31:0] a, input logic [31:0] wd);
        MemRead_In = rd; MemWrite_In = wr; ByteSel_In = sel; Addr_In = a; WData_In = wd;
    endtask

    task automatic clr_acc();
        set_acc(0, 0, 2'b00, 32'h0, 32'h0);
    endtask

    // Present an access, ack it in WAIT cycle ack_at, run through DONE; returns in the next IDLE cycle.
    task automatic access(input bit rd, input bit wr, input logic [1:0] sel, input logic [31:0] a,
                          input logic [31:0] wd, input int ack_at, input logic [31:0] rdat);
        set_acc(rd, wr, sel, a, wd);
        step();
        repeat (ack_at - 1) step();
        Mem_Ack = 1; Mem_RData = rdat;
        step();
        Mem_Ack = 0; Mem_RData = 32'h5555_AAAA;
        step();
    endtask

    initial begin
        Reset_n = 0; Mem_Ack = 0; Mem_RData = 0;
        clr_acc();
        clear_counts();
        #8;
        chk("reset_req", 32'(Mem_Req), 0);
        chk("reset_stall", 32'(Stall), 0);
        chk("reset_rdata", RData_Out, 0);
        #4 Reset_n = 1;
        step();

        // 1: word read at 0x100, ack in 3rd WAIT cycle
        clear_counts();
        access(1, 0, 2'b00, 32'h100, 32'h0, 3, 32'hDEAD_BEEF);
        clr_acc();
        chk("t1_stall_cycles", 32'(stall_cnt), 4);
        chk("t1_valid_cycles", 32'(valid_cnt), 1);
        chk("t1_rdata", RData_Out, 32'hDEAD_BEEF);
        chk("t1_addr", seen_addr, 32'h100);
        chk("t1_be", 32'(seen_be), 32'hF);
        chk("t1_we", 32'(seen_we), 0);

        // 2: byte write 0xA5 at 0x203, immediate ack
        step();
        clear_counts();
        access(0, 1, 2'b10, 32'h203, 32'h0000_00A5, 1, 32'h0);
        clr_acc();
        chk("t2_stall_cycles", 32'(stall_cnt), 2);
        chk("t2_valid_cycles", 32'(valid_cnt), 0);
        chk("t2_we", 32'(seen_we), 1);
        chk("t2_be", 32'(seen_be), 32'h8);
        chk("t2_wdata", seen_wdata, 32'hA5A5_A5A5);
        chk("t2_rdata_held", RData_Out, 32'hDEAD_BEEF);

        // both strobes high on a half access: write wins, upper lanes
        clear_counts();
        access(1, 1, 2'b01, 32'h202, 32'h1234_BEEF, 2, 32'h0);
        clr_acc();
        chk("tw_we", 32'(seen_we), 1);
        chk("tw_be", 32'(seen_be), 32'hC);
        chk("tw_wdata", seen_wdata, 32'hBEEF_BEEF);
        chk("tw_valid_cycles", 32'(valid_cnt), 0);

        // stray ack in IDLE is ignored
        Mem_Ack = 1; step(); Mem_Ack = 0;

        // 3: misaligned half read
        clear_counts();
        set_acc(1, 0, 2'b01, 32'h101, 32'h0);
        step();
        clr_acc();
        step();
        chk("t3_mis_err", 32'(Misalign_Err), 1);
        chk("t3_req_cycles", 32'(req_cnt), 0);
        chk("t3_stall_cycles", 32'(stall_cnt), 0);

        // 5: back-to-back loads, second presented in the IDLE cycle after DONE
        clear_counts();
        access(1, 0, 2'b00, 32'h10, 32'h0, 2, 32'h1111_2222);
        chk("t5_first_rdata", RData_Out, 32'h1111_2222);
        access(1, 0, 2'b00, 32'h14, 32'h0, 1, 32'h3333_4444);
        clr_acc();
        chk("t5_req_cycles", 32'(req_cnt), 3);
        chk("t5_stall_cycles", 32'(stall_cnt), 5);
        chk("t5_valid_cycles", 32'(valid_cnt), 2);
        chk("t5_rdata", RData_Out, 32'h3333_4444);
        chk("t5_mis_sticky", 32'(Misalign_Err), 1);

        // 4: read with no ack times out after TIMEOUT WAIT cycles
        clear_counts();
        set_acc(1, 0, 2'b00, 32'h40, 32'h0);
        step();
        repeat (TIMEOUT) step();
        clr_acc();
        chk("t4_req_cycles", 32'(req_cnt), TIMEOUT);
        chk("t4_req_low", 32'(Mem_Req), 0);
        chk("t4_tmo", 32'(Timeout_Err), 1);
        Mem_Ack = 1; step(); Mem_Ack = 0;
        repeat (5) step();
        chk("t4_stall_held", 32'(Stall), 1);
        chk("t4_req_still_low", 32'(Mem_Req), 0);
        #2 Reset_n = 0;
        #1;
        chk("t4_rst_stall", 32'(Stall), 0);
        chk("t4_rst_tmo", 32'(Timeout_Err), 0);
        chk("t4_rst_mis", 32'(Misalign_Err), 0);
        #3 Reset_n = 1;
        step();

        // 6: reset pulsed mid-WAIT with the access still presented
        set_acc(1, 0, 2'b00, 32'h80, 32'h0);
        step();
        step();
        #2 Reset_n = 0;
        #1;
        chk("t6_req", 32'(Mem_Req), 0);
        chk("t6_stall", 32'(Stall), 0);
        chk("t6_addr", Mem_Addr, 0);
        chk("t6_rdata", RData_Out, 0);
        clr_acc();
        #3 Reset_n = 1;
        step();
        chk("t6_idle_req", 32'(Mem_Req), 0);
        chk("t6_idle_stall", 32'(Stall), 0);
        clear_counts();
        access(1, 0, 2'b00, 32'h84, 32'h0, 1, 32'hCAFE_F00D);
        clr_acc();
        step();
        chk("t6_after_stall_cycles", 32'(stall_cnt), 2);
        chk("t6_after_rdata", RData_Out, 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
